// File: rtl/max_tracker_if.sv
// max_tracker_if: sample/result valid-ready bus for max_tracker; MAX_TRACKER_MIN_EN adds the min fields.
interface max_tracker_if #(parameter int WIDTH = 4, parameter int WIN = 8);
  localparam int IDX_W = $clog2(WIN);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
`ifdef MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] out_min;
  logic [IDX_W-1:0] out_min_idx;
`endif
  modport slave (
    input  in_valid, in_data, clear, out_ready,
`ifdef MAX_TRACKER_MIN_EN
    output out_min, out_min_idx,
`endif
    output in_ready, out_valid, out_max, out_idx
  );
  modport master (
    output in_valid, in_data, clear, out_ready,
`ifdef MAX_TRACKER_MIN_EN
    input  out_min, out_min_idx,
`endif
    input  in_ready, out_valid, out_max, out_idx
  );
endinterface

// File: rtl/max_tracker.sv
// max_tracker: reduces each WIN-sample window to its max and position; MAX_TRACKER_MIN_EN also tracks the min.
module max_tracker #(
  parameter int WIDTH = 4,
  parameter int WIN   = 8
) (
  input logic         clk,
  input logic         rst,
  max_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(WIN);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_cnt, r_idx, r_out_idx;
  logic [WIDTH-1:0] r_max, r_out_max;
  logic             w_ready, w_acc, w_first, w_last, w_take;
  logic [WIDTH-1:0] w_max;
  logic [IDX_W-1:0] w_idx;
`ifdef MAX_TRACKER_MIN_EN
  logic [IDX_W-1:0] r_midx, r_out_midx;
  logic [WIDTH-1:0] r_min, r_out_min;
  logic             w_mtake;
  logic [WIDTH-1:0] w_min;
  logic [IDX_W-1:0] w_midx;
`endif
  always_comb begin
    w_ready = (r_state == ACCUM) && !bus.clear;
    w_acc   = bus.in_valid && w_ready;
    w_first = r_cnt == '0;
    w_last  = r_cnt == IDX_W'(WIN - 1);
    w_take  = w_first || (bus.in_data > r_max);
    w_max   = w_take ? bus.in_data : r_max;
    w_idx   = w_take ? r_cnt : r_idx;
`ifdef MAX_TRACKER_MIN_EN
    w_mtake = w_first || (bus.in_data < r_min);
    w_min   = w_mtake ? bus.in_data : r_min;
    w_midx  = w_mtake ? r_cnt : r_midx;
`endif
  end
  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_state == HOLD;
  assign bus.out_max   = r_out_max;
  assign bus.out_idx   = r_out_idx;
`ifdef MAX_TRACKER_MIN_EN
  assign bus.out_min     = r_out_min;
  assign bus.out_min_idx = r_out_midx;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACCUM;
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_out_max <= '0;
      r_out_idx <= '0;
    end else if (bus.clear) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
    end else if (r_state == HOLD) begin
      if (bus.out_ready) r_state <= ACCUM;
    end else if (w_acc) begin
      r_max <= w_max;
      r_idx <= w_idx;
      if (w_last) begin
        r_out_max <= w_max;
        r_out_idx <= w_idx;
        r_cnt     <= '0;
        r_state   <= HOLD;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`ifdef MAX_TRACKER_MIN_EN
  // min path shares count/state with the max path; only its own registers live here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min      <= '0;
      r_midx     <= '0;
      r_out_min  <= '0;
      r_out_midx <= '0;
    end else if (!bus.clear && r_state == ACCUM && w_acc) begin
      r_min  <= w_min;
      r_midx <= w_midx;
      if (w_last) begin
        r_out_min  <= w_min;
        r_out_midx <= w_midx;
      end
    end
  end
`endif
endmodule

// File: tb/tb_max_tracker.sv
// tb_max_tracker: randomized scoreboard bench for max_tracker with a window-list reference model.
module tb_max_tracker;
  localparam int WIDTH = 4;
  localparam int WIN   = 8;
  localparam int IDX_W = $clog2(WIN);
  typedef struct {
    logic [WIDTH-1:0] mx;
    logic [IDX_W-1:0] ix;
    logic [WIDTH-1:0] mn;
    logic [IDX_W-1:0] mi;
  } res_t;
  logic clk = 0;
  logic rst = 1;
  logic run = 0;
  logic rnd_rdy = 0;
  logic exp_hold = 0;
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] win_q[$];
  res_t exp_q[$];
  max_tracker_if #(.WIDTH(WIDTH), .WIN(WIN)) bus ();
  max_tracker #(.WIDTH(WIDTH), .WIN(WIN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t reduce(input logic [WIDTH-1:0] s[$]);
    res_t r;
    r.mx = s[0]; r.ix = 0; r.mn = s[0]; r.mi = 0;
    for (int i = 1; i < s.size(); i++) begin
      if (s[i] > r.mx) begin r.mx = s[i]; r.ix = IDX_W'(i); end
      if (s[i] < r.mn) begin r.mn = s[i]; r.mi = IDX_W'(i); end
    end
    return r;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q.delete(); exp_q.delete(); exp_hold = 0;
    end else if (bus.clear) begin
      win_q.delete();
      if (exp_hold) void'(exp_q.pop_front());
      exp_hold = 0;
    end else if (exp_hold) begin
      if (bus.out_ready) begin void'(exp_q.pop_front()); exp_hold = 0; end
    end else if (bus.in_valid) begin
      win_q.push_back(bus.in_data);
      if (win_q.size() == WIN) begin
        exp_q.push_back(reduce(win_q));
        win_q.delete();
        exp_hold = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("in_ready", bus.in_ready, !exp_hold && !bus.clear);
      chk("out_valid", bus.out_valid, exp_hold);
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("out_max", bus.out_max, exp_q[0].mx);
        chk("out_idx", bus.out_idx, exp_q[0].ix);
`ifdef MAX_TRACKER_MIN_EN
        chk("out_min", bus.out_min, exp_q[0].mn);
        chk("out_min_idx", bus.out_min_idx, exp_q[0].mi);
`endif
      end
    end
  end
  always @(posedge clk) if (rnd_rdy) begin #2; bus.out_ready = 1'($urandom_range(0, 1)); end
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic send(input logic [WIDTH-1:0] d);
    logic ok;
    int t;
    t = 0;
    bus.in_valid = 1; bus.in_data = d;
    do begin @(negedge clk); ok = bus.in_ready; @(posedge clk); #2; t++; end while (!ok && t < 100);
    bus.in_valid = 0;
    chk("accept", ok, 1);
  endtask
  task automatic pulse_clear();
    bus.clear = 1; idle(1); bus.clear = 0;
  endtask
  task automatic async_rst();
    #1 rst = 1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #2 rst = 0;
  endtask
  task automatic send_list(input logic [WIDTH-1:0] s[$], input bit gaps);
    foreach (s[i]) begin
      if (gaps) idle($urandom_range(0, 1));
      send(s[i]);
    end
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.clear = 0; bus.out_ready = 1;
    idle(2);
    rst = 0;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_max", bus.out_max, 0);
    chk("reset_out_idx", bus.out_idx, 0);
    run = 1;
    send_list('{3, 9, 2, 9, 1, 0, 7, 5}, 0);
    idle(2);
    bus.out_ready = 0;
    send_list('{15, 15, 15, 15, 15, 15, 15, 15}, 0);
    bus.in_valid = 1; bus.in_data = 2;
    idle(5);
    bus.out_ready = 1;
    send(2);
    send_list('{1, 4, 3, 6, 5, 0, 7}, 0);
    idle(1);
    send_list('{4, 4, 4, 4, 4, 4, 4, 12}, 1);
    idle(1);
    send_list('{3, 14, 2, 7, 1}, 0);
    bus.in_valid = 1; bus.in_data = 15; bus.clear = 1;
    idle(1);
    bus.clear = 0; bus.in_valid = 0;
    send_list('{1, 2, 3, 4, 5, 6, 7, 8}, 0);
    idle(1);
    send_list('{9, 13, 11}, 0);
    async_rst();
    bus.out_ready = 0;
    send_list('{5, 3, 10, 1, 2, 8, 4, 7}, 0);
    idle(2);
    async_rst();
    bus.out_ready = 1;
    send_list('{6, 6, 6, 6, 6, 6, 6, 6}, 0);
    send_list('{2, 11, 5, 11, 1, 3, 0, 9}, 0);
    send_list('{1, 2, 0, 3, 1, 2, 0, 1}, 0);
    idle(1);
    bus.out_ready = 0;
    send_list('{7, 7, 9, 1, 2, 3, 4, 5}, 0);
    idle(1);
    pulse_clear();
    send_list('{8, 1, 8, 0, 0, 9, 2, 3}, 0);
    idle(1);
    bus.out_ready = 1; bus.clear = 1;
    idle(1);
    bus.clear = 0;
    rnd_rdy = 1;
    for (int w = 0; w < 30; w++) begin
      for (int i = 0; i < WIN; i++) begin
        idle($urandom_range(0, 2) == 0 ? 1 : 0);
        if ($urandom_range(0, 40) == 0) pulse_clear();
        send(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
      end
    end
    rnd_rdy = 0;
    idle(1);
    bus.out_ready = 1;
    idle(3);
    chk("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/max_tracker.md
Name: max_tracker

Overview:
- Streaming, parametrised maximum finder.
- Consumes a stream of unsigned samples over a valid/ready handshake and reduces each window of WIN consecutive samples to its maximum value plus the position of that maximum within the window.
- Sits between a sample source and a downstream consumer.
- Output is held on a valid/ready handshake until accepted, then the next window starts.

Parameters:
WIDTH, 4, sample width in bits; unsigned compare; legal range 1..32.
WIN, 8, samples per window; legal range 2..256.
IDX_W, $clog2(WIN), width of the index output; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  sample present on in_data.
in_ready  output  1  block accepts a sample this cycle.
in_data  input  WIDTH  sample, unsigned.
clear  input  1  synchronous abort of the current window and any held result.
out_valid  output  1  result held on out_max/out_idx.
out_ready  input  1  consumer accepts result.
out_max  output  WIDTH  maximum of the completed window.
out_idx  output  IDX_W  position (0..WIN-1) of out_max within the window.

Behaviour:
- Clock, reset and FSM:
  - One clock (clk). Reset is asynchronous and active-high (rst).
  - FSM states: ACCUM, HOLD. Reset state is ACCUM.
  - Reset values: in_ready=1, out_valid=0, out_max=0, out_idx=0, sample count=0, running max=0, running index=0.
- Sample acceptance:
  - A sample is accepted when in_valid && in_ready on a rising edge.
  - in_ready = (state==ACCUM) && !clear. Combinational; does not depend on in_valid.
- ACCUM state:
  - The first accepted sample (count==0) loads the running max unconditionally and sets the running index to 0.
  - A later sample replaces the running max only if strictly greater. On a tie the earliest index is kept.
  - The running index records the count value at which the current max was taken.
  - The count increments on each accepted sample.
  - When the WIN-th sample is accepted (count==WIN-1):
    - The final comparison includes that sample.
    - The result is registered into out_max/out_idx.
    - out_valid=1 from the next cycle; state moves to HOLD; count returns to 0.
  - Latency: out_valid is high exactly 1 cycle after the last sample's accepting edge.
- HOLD state:
  - in_ready=0.
  - out_max/out_idx are stable while out_valid=1.
  - When out_valid && out_ready: out_valid=0 on the next cycle and the state returns to ACCUM. The first new sample can be accepted in that cycle.
  - Back-to-back bubble: one idle cycle per window minimum.
- Gaps: in_valid may drop mid-window; the running state holds indefinitely.
- clear:
  - In ACCUM: discard partial window (count=0). A sample offered in the same cycle is not accepted.
  - In HOLD: drop out_valid to 0 and return to ACCUM. out_max/out_idx retain their last values but are meaningless.
  - clear together with out_ready in HOLD: same as clear.
- Reset mid-window or mid-HOLD: all state returns to reset values immediately; no partial result is emitted.
- Width: comparisons are WIDTH-bit unsigned. The count is IDX_W bits (IDX_W+1 if WIN is a power of two is not needed, since count wraps at WIN-1 explicitly).

Optional Feature:
MAX_TRACKER_MIN_EN
- Defined:
  - Adds ports out_min (output, WIDTH) and out_min_idx (output, IDX_W).
  - The window minimum is tracked in parallel with the same rules: first sample loads, replacement only if strictly less, earliest index on ties.
  - Outputs have the same timing and hold as out_max. Reset value 0.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- WIN=8, WIDTH=4: stream 3,9,2,9,1,0,7,5 with in_valid continuous and out_ready=1 -> out_valid one cycle after 8th sample; out_max=9, out_idx=1 (tie keeps earliest); with MIN_EN, out_min=0, out_min_idx=5.
- Stream 8 samples all 0xF with out_ready=0 for 5 cycles -> out_max=15, out_idx=0, held stable 5 cycles. in_ready=0 throughout HOLD; a 9th sample offered is not accepted until after the out_ready handshake.
- Random in_valid gaps (~50% duty) over window 4,4,4,4,4,4,4,12 -> out_max=12, out_idx=7; count unaffected by idle cycles.
- After 5 accepted samples (max 14), assert clear for 1 cycle with in_valid=1 -> that sample is dropped. The next 8 samples 1..8 give out_max=8, out_idx=7.
- Assert rst asynchronously mid-window and again during HOLD -> out_valid=0, in_ready=1 immediately. The next full window 6,6,6,6,6,6,6,6 gives out_max=6, out_idx=0.
- Two back-to-back windows with out_ready=1 -> second window's first sample accepted in the cycle out_valid falls. Results are each window's own max; no carry-over of the running max.
